// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI master.
package spi_pkg;

  localparam int CLK_DIV_MIN = 4;
  localparam int SPI_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_GAP,
    ST_LAG
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period counter: produces SCK (idle low) and strobes that fire on the
// cycle SCK is driven 0->1 (rise) or 1->0 (fall).
module spi_sck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    rise  = 1'b0;
    fall  = 1'b0;
    if (clr) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        sck_d = ~sck_q;
        rise  = ~sck_q;
        fall  = sck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together and simulation matches the synthesised netlist.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first. SS is held low across a burst
// of bytes ended by tx_last; every received byte is returned with rx_valid.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int SS_LEAD = 4,
  parameter int SS_LAG  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SPI_W-1:0] tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  output logic [SPI_W-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             SCK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             SS
);

  localparam int               BIT_W    = $clog2(SPI_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_W - 1);
  localparam int               DLY_MAX  = (SS_LEAD > SS_LAG) ? SS_LEAD : SS_LAG;
  localparam int               DLY_W    = $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] LEAD_END = DLY_W'(SS_LEAD - 1);
  localparam logic [DLY_W-1:0] LAG_END  = DLY_W'(SS_LAG - 1);

  if (CLK_DIV < CLK_DIV_MIN) begin : g_clk_div_chk
    $error("spi_master: CLK_DIV must be at least %0d", CLK_DIV_MIN);
  end

  spi_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [SPI_W-1:0] tx_sr_q, tx_sr_d;
  logic [SPI_W-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_W-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             last_q, last_d;
  logic             tx_ready_q, tx_ready_d;
  logic             ss_q, ss_d;
  logic             busy_q, busy_d;
  logic             miso_s1_q, miso_s1_d;
  logic             miso_s2_q, miso_s2_d;

  logic accept;
  logic sck_en, sck_rise, sck_fall;

  assign sck_en = (state_q == ST_SHIFT);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk   (clk),
    .reset (reset),
    .en    (sck_en),
    .clr   (~sck_en),
    .sck   (SCK),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_comb begin
    accept     = tx_valid && tx_ready_q;
    state_d    = state_q;
    bit_d      = (state_q == ST_SHIFT) ? bit_q : '0;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    miso_s1_d  = MISO;
    miso_s2_d  = miso_s1_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (accept) begin
          state_d = (state_q == ST_IDLE) ? ST_LEAD : ST_SHIFT;
          tx_sr_d = tx_data;
          last_d  = tx_last;
        end
      end
      ST_LEAD: if (dly_q == LEAD_END) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (sck_rise) rx_sr_d = {rx_sr_q[SPI_W-2:0], miso_s2_q};
        if (sck_fall) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? ST_LAG : ST_GAP;
          end else begin
            tx_sr_d = {tx_sr_q[SPI_W-2:0], 1'b0};
          end
        end
      end
      ST_LAG:  if (dly_q == LAG_END) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    dly_d = (state_d == state_q && (state_q == ST_LEAD || state_q == ST_LAG))
            ? dly_q + 1'b1 : '0;
    // Ready is derived from the current state, so it rises one cycle after
    // entering IDLE/GAP and never coincides with rx_valid.
    tx_ready_d = (state_q == ST_IDLE || state_q == ST_GAP) && !accept;
    ss_d       = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dly_q      <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      tx_ready_q <= tx_ready_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      miso_s1_q  <= miso_s1_d;
      miso_s2_q  <= miso_s2_d;
    end
  end

  // The MSB of the shift register is the MOSI flop itself.
  assign MOSI     = tx_sr_q[SPI_W-1];
  assign SS       = ss_q;
  assign busy     = busy_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: bus monitor, mode-0 loopback slave model and
// hand-computed expectations for each scenario.
module tb_spi_master;

  localparam int CLK_DIV = 8;
  localparam int SS_LEAD = 4;
  localparam int SS_LAG  = 4;
  localparam int WIN_LEN = SS_LEAD + 16 * CLK_DIV + SS_LAG;
  localparam int BUDGET  = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso = 1'b0;
  logic       ss;

  spi_master #(.CLK_DIV(CLK_DIV), .SS_LEAD(SS_LEAD), .SS_LAG(SS_LAG)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .SCK      (sck),
    .MOSI     (mosi),
    .MISO     (miso),
    .SS       (ss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state
  logic       sck_prev = 1'b0;
  logic       ss_prev  = 1'b1;
  int         ss_len = 0, win_pulses = 0, hi_len = 0, rise_total = 0;
  int         mosi_bits = 0, rv_run = 0, rv_max = 0;
  logic [7:0] mosi_sh = 8'h00;
  int         win_len_q[$], win_pulse_q[$], gap_q[$];
  logic [7:0] rx_q[$], mosi_q[$];

  // Slave model state
  logic       loop_en  = 1'b0;
  logic       miso_fix = 1'b0;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  int         s_bit = 0;

  always @(negedge clk) begin : mon
    logic rise_e, fall_e;
    rise_e = (sck === 1'b1) && (sck_prev === 1'b0);
    fall_e = (sck === 1'b0) && (sck_prev === 1'b1);

    if (ss === 1'b0) begin
      ss_len++;
      if (rise_e) win_pulses++;
    end
    if (rise_e) begin
      rise_total++;
      mosi_sh = {mosi_sh[6:0], mosi};
      mosi_bits++;
      if (mosi_bits == 8) begin
        mosi_q.push_back(mosi_sh);
        mosi_bits = 0;
      end
    end
    if (ss === 1'b1 && ss_prev === 1'b0) begin
      win_len_q.push_back(ss_len);
      win_pulse_q.push_back(win_pulses);
      ss_len = 0;
      win_pulses = 0;
      mosi_bits = 0;
    end
    if (ss === 1'b1) hi_len++;
    if (ss === 1'b0 && ss_prev === 1'b1) begin
      gap_q.push_back(hi_len);
      hi_len = 0;
    end

    if (rx_valid === 1'b1) begin
      rx_q.push_back(rx_data);
      rv_run++;
      if (rv_run > rv_max) rv_max = rv_run;
    end else begin
      rv_run = 0;
    end

    // Mode-0 slave: first reply 0x00, then each reply is the previous byte + 2.
    if (!loop_en) begin
      s_tx  = 8'h00;
      s_bit = 0;
      miso  = miso_fix;
    end else begin
      if (ss === 1'b0 && ss_prev === 1'b1) begin
        s_bit = 0;
        miso  = s_tx[7];
      end
      if (rise_e) s_rx = {s_rx[6:0], mosi};
      if (fall_e && ss === 1'b0) begin
        s_bit++;
        if (s_bit == 8) begin
          s_tx  = s_rx + 8'd2;
          s_bit = 0;
        end
        miso = s_tx[7-s_bit];
      end
    end

    sck_prev = sck;
    ss_prev  = ss;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic hold);
    int n = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) check("send_timeout", 0, 1);
    tick();
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || ss !== 1'b1) && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, wb, mb, gb, rt, n, bad;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) tick();

    check("rst_ss",       ss,       1);
    check("rst_sck",      sck,      0);
    check("rst_mosi",     mosi,     0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data",  rx_data,  8'h00);
    check("rst_busy",     busy,     0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", tx_ready, 1);

    // Single byte, MISO held high
    miso_fix = 1'b1;
    repeat (3) tick();
    rb = rx_q.size(); wb = win_len_q.size(); mb = mosi_q.size();
    send(8'hA5, 1'b1, 1'b0);
    wait_idle();
    check("single_windows", win_len_q.size() - wb, 1);
    check("single_ss_len",  win_len_q[wb],   WIN_LEN);
    check("single_pulses",  win_pulse_q[wb], 8);
    check("single_mosi",    mosi_q[mb],      8'hA5);
    check("single_rx_cnt",  rx_q.size() - rb, 1);
    check("single_rx_data", rx_q[rb],        8'hFF);

    // Loopback burst of three bytes
    loop_en = 1'b1;
    tick();
    rb = rx_q.size(); wb = win_len_q.size(); mb = mosi_q.size();
    send(8'h05, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    wait_idle();
    check("loop_windows", win_len_q.size() - wb, 1);
    check("loop_pulses",  win_pulse_q[wb], 24);
    check("loop_rx_cnt",  rx_q.size() - rb, 3);
    check("loop_rx0",     rx_q[rb],     8'h00);
    check("loop_rx1",     rx_q[rb + 1], 8'h07);
    check("loop_rx2",     rx_q[rb + 2], 8'h12);
    check("loop_mosi1",   mosi_q[mb + 1], 8'h10);

    // GAP stall of 100 cycles between two bytes
    loop_en  = 1'b0;
    miso_fix = 1'b0;
    repeat (3) tick();
    rb = rx_q.size(); wb = win_len_q.size(); mb = mosi_q.size();
    send(8'h81, 1'b0, 1'b0);
    n = 0;
    while (tx_ready !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) check("gap_ready_timeout", 0, 1);
    bad = 0;
    repeat (100) begin
      if (ss !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) bad++;
      tick();
    end
    check("gap_stall_bad", bad, 0);
    send(8'h42, 1'b1, 1'b0);
    wait_idle();
    check("gap_windows", win_len_q.size() - wb, 1);
    check("gap_pulses",  win_pulse_q[wb], 16);
    check("gap_rx_cnt",  rx_q.size() - rb, 2);
    check("gap_mosi0",   mosi_q[mb],     8'h81);
    check("gap_mosi1",   mosi_q[mb + 1], 8'h42);

    // Reset after three SCK rises
    miso_fix = 1'b1;
    repeat (3) tick();
    rb = rx_q.size(); wb = win_len_q.size(); rt = rise_total;
    send(8'h99, 1'b1, 1'b0);
    n = 0;
    while (rise_total < rt + 3 && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) check("rise_timeout", 0, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_ss",   ss,   1);
    check("mid_rst_sck",  sck,  0);
    check("mid_rst_busy", busy, 0);
    tick();
    tick();
    check("mid_rst_ready", tx_ready, 0);
    check("mid_rst_mosi",  mosi,     0);
    reset = 1'b0;
    tick();
    check("mid_rst_ready_after", tx_ready, 1);
    check("mid_rst_no_rx",  rx_q.size() - rb, 0);
    check("mid_rst_pulses", win_pulse_q[wb], 3);
    repeat (3) tick();
    rb = rx_q.size(); wb = win_len_q.size(); mb = mosi_q.size();
    send(8'h3C, 1'b1, 1'b0);
    wait_idle();
    check("post_rst_ss_len", win_len_q[wb], WIN_LEN);
    check("post_rst_mosi",   mosi_q[mb],    8'h3C);
    check("post_rst_rx",     rx_q[rb],      8'hFF);

    // Back-to-back single-byte bursts with tx_valid held high
    miso_fix = 1'b0;
    repeat (3) tick();
    wb = win_len_q.size(); mb = mosi_q.size(); gb = gap_q.size();
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b1);
    send(8'h33, 1'b1, 1'b0);
    wait_idle();
    check("b2b_windows", win_len_q.size() - wb, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_pulses%0d", i), win_pulse_q[wb + i], 8);
      check($sformatf("b2b_len%0d", i),    win_len_q[wb + i],   WIN_LEN);
    end
    check("b2b_gap1", gap_q[gb + 1] >= 1, 1);
    check("b2b_gap2", gap_q[gb + 2] >= 1, 1);
    check("b2b_mosi2", mosi_q[mb + 2], 8'h33);

    check("rx_valid_width", rv_max, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, driving SCK/MOSI/SS towards the FPGA-side SPI slave stage and sampling its MISO.
- Sits directly upstream of that slave and is used on-chip for loopback bring-up and the bench harness.
- Accepts bytes on a valid/ready stream, holds SS low across a multi-byte burst terminated by tx_last, and returns each received byte with a one-cycle rx_valid pulse.

Parameters:
- CLK_DIV, 8, clk cycles per SCK half-period; legal values ≥ 4, because the slave needs 3 clk cycles to see an edge.
- SS_LEAD, 4, clk cycles between SS falling and the first SCK rising-phase start (SCK low).
- SS_LAG, 4, clk cycles after the last SCK falling edge before SS rises.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_last  in  1  byte is the last of the burst; sampled with tx_data
- tx_ready  out  1  master can accept a byte
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse, rx_data updated
- busy  out  1  SS asserted (low) or transfer pending
- SCK  out  1  SPI clock, idle low
- MOSI  out  1  master out, slave in
- MISO  in  1  master in, slave out; asynchronous, 2-flop synchronised internally
- SS  out  1  slave select, active low

Behaviour:
- Reset values: SS=1, SCK=0, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0x00, busy=0. All registers are cleared, including the MISO synchroniser.
- Reset mid-transfer: next cycle SS=1 and SCK=0. The partial byte is discarded and no rx_valid is issued.
- Handshake: a transfer happens on tx_valid && tx_ready. tx_ready=1 only in IDLE and GAP. tx_data and tx_last are captured on acceptance.
- States:
  - IDLE: SS=1, SCK=0, tx_ready=1. On accept go to LEAD; SS=0 and MOSI=tx_data[7] from the next cycle.
  - LEAD: SCK=0 for SS_LEAD cycles, then go to SHIFT.
  - SHIFT: 8 bits. Each bit is CLK_DIV cycles with SCK=0, then CLK_DIV cycles with SCK=1 (16*CLK_DIV cycles per byte).
    - On the cycle SCK is driven 0→1, the synchronised MISO is shifted into the rx shift register LSB-end.
    - On the cycle SCK is driven 1→0, MOSI advances to the next lower bit. After bit 0, MOSI is held.
    - A 3-bit bit counter and a half-period counter are sized to CLK_DIV.
  - After the 8th falling edge: rx_data is loaded and rx_valid=1 for exactly that cycle.
    - If the captured tx_last=1, go to LAG.
    - Otherwise go to GAP.
  - GAP: SS stays 0, SCK=0, tx_ready=1, and the state waits indefinitely.
    - On accept, MOSI=new bit7 from the next cycle, then go to SHIFT with a fresh low phase (no LEAD).
  - LAG: SCK=0 and SS=0 for SS_LAG cycles, then SS=1 and go to IDLE. IDLE holds at least 1 cycle, so SS is high for ≥ 1 clk between bursts.
- busy = (state != IDLE).
- The accept cycle in IDLE/GAP and rx_valid never coincide; rx_valid precedes GAP by one cycle.
- tx_valid held while not ready has no effect. tx_data may change freely until accepted.
- MISO latency: the sampled bit reflects the pin 2 clk before the SCK rising cycle. The slave therefore must update MISO within CLK_DIV−2 clk of the falling edge.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, LEAD, SHIFT, GAP, LAG);
  - CLK_DIV_MIN = 4;
  - SPI byte width = 8.
- One sub-module, spi_sck_gen: half-period counter producing SCK plus one-cycle rise/fall strobes, with enable and synchronous clear.

Test Plan:
- Reset check: assert reset for 3 cycles mid-stream. Required: SS=1, SCK=0, MOSI=0, tx_ready=0 during reset; tx_ready=1 on the cycle after reset deasserts.
- Single byte, bench MISO held at 1, send 0xA5 with tx_last=1, CLK_DIV=8.
  - MOSI bits 1,0,1,0,0,1,0,1 are valid at each SCK rise.
  - Exactly 8 SCK pulses; rx_data=0xFF with rx_valid for 1 cycle.
  - SS low for SS_LEAD+128+SS_LAG cycles.
- Loopback against a slave model that returns the previous received byte + 2, burst 0x05, 0x10, 0x00 (last on the third).
  - rx sequence 0x00, 0x07, 0x12.
  - SS stays low throughout the burst.
- GAP stall: hold tx_valid=0 for 100 cycles after byte 1 of a burst. Required: SS stays 0, SCK stays 0, tx_ready=1; byte 2 then transfers correctly.
- Reset mid-byte: assert reset after 3 SCK rises. Required: no rx_valid; SS=1 next cycle; a following single byte 0x3C transfers correctly.
- Back-to-back bursts: tx_valid held high with tx_last on every byte. Required: SS deasserts for ≥ 1 cycle between bytes, and each SS-low window contains exactly 8 SCK pulses.
